// File: rtl/mod_differencer.sv
// Modulo-M differencer: recovers d[n] = (x[n] - x[n-1]) mod M from a phase stream,
// flags each wrap-around and keeps a running wrap count.
//
// state   | meaning
// S_EMPTY | no reference sample held; next legal sample becomes the reference
// S_RUN   | reference held; each legal sample produces one difference
module mod_differencer #(
  parameter int M  = 100,
  parameter int CW = 16,
  localparam int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_phase,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_diff,
  output logic          out_wrap,
  output logic [CW-1:0] wrap_cnt,
  output logic          primed,
  output logic          err
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [W:0]   M_EXT = (W+1)'(M);
  localparam logic [W-1:0] M_LO  = W'(M);

  state_t        r_state,     w_state_nxt;
  logic [W-1:0]  r_prev,      w_prev_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic [W-1:0]  r_out_diff,  w_out_diff_nxt;
  logic          r_out_wrap,  w_out_wrap_nxt;
  logic [CW-1:0] r_wrap_cnt,  w_wrap_cnt_nxt;
  logic          r_err,       w_err_nxt;

  logic          w_in_ready;
  logic          w_in_xfer;
  logic          w_legal;
  logic          w_below;
  logic [W-1:0]  w_diff;

  assign w_in_ready = ~restart & (~r_out_valid | out_ready);
  assign w_in_xfer  = in_valid & w_in_ready;
  assign w_legal    = ({1'b0, in_phase} < M_EXT);
  assign w_below    = (in_phase < r_prev);
  // True result is below M <= 2^W, so modulo-2^W arithmetic yields it exactly.
  assign w_diff     = in_phase - r_prev + (w_below ? M_LO : '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_out_valid_nxt = r_out_valid & ~out_ready;
    w_out_diff_nxt  = r_out_diff;
    w_out_wrap_nxt  = r_out_wrap;
    w_wrap_cnt_nxt  = r_wrap_cnt;
    w_err_nxt       = r_err;

    if (restart) begin
      w_state_nxt     = S_EMPTY;
      w_out_valid_nxt = 1'b0;
      w_wrap_cnt_nxt  = '0;
      w_err_nxt       = 1'b0;
    end else if (w_in_xfer) begin
      if (!w_legal) begin
        w_err_nxt = 1'b1;
      end else begin
        case (r_state)
          S_EMPTY: begin
            w_prev_nxt  = in_phase;
            w_state_nxt = S_RUN;
          end
          S_RUN: begin
            w_prev_nxt      = in_phase;
            w_out_diff_nxt  = w_diff;
            w_out_wrap_nxt  = w_below;
            w_out_valid_nxt = 1'b1;
            if (w_below) w_wrap_cnt_nxt = r_wrap_cnt + CW'(1);
          end
          default: w_state_nxt = S_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_out_valid <= 1'b0;
      r_out_diff  <= '0;
      r_out_wrap  <= 1'b0;
      r_wrap_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_prev      <= w_prev_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_diff  <= w_out_diff_nxt;
      r_out_wrap  <= w_out_wrap_nxt;
      r_wrap_cnt  <= w_wrap_cnt_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_diff  = r_out_diff;
  assign out_wrap  = r_out_wrap;
  assign wrap_cnt  = r_wrap_cnt;
  assign primed    = (r_state == S_RUN);
  assign err       = r_err;

endmodule

// File: tb/tb_mod_differencer.sv
// Bench for mod_differencer: behavioural model compared every cycle, plus literal
// expectations for the directed scenarios and randomized streams.
module tb_mod_differencer;
  localparam int M  = 100;
  localparam int CW = 16;
  localparam int W  = $clog2(M);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_phase = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_diff;
  logic          out_wrap;
  logic [CW-1:0] wrap_cnt;
  logic          primed;
  logic          err;

  mod_differencer #(.M(M), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_phase(in_phase),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_wrap(out_wrap),
    .wrap_cnt(wrap_cnt), .primed(primed), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit done = 0;
  bit rand_rdy = 0;

  // model state
  int m_ov = 0, m_od = 0, m_ow = 0, m_cnt = 0, m_err = 0, m_primed = 0, m_prev = 0;
  int log_d[$];
  int log_w[$];
  int exp_d[$];
  int exp_w[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: the stream semantics of the block written as plain arithmetic.
  always @(posedge clk or negedge rst_n) begin
    int ph;
    bit rdy;
    if (!rst_n) begin
      m_ov = 0; m_od = 0; m_ow = 0; m_cnt = 0; m_err = 0; m_primed = 0; m_prev = 0;
    end else begin
      rdy = !restart && (m_ov == 0 || out_ready);
      ph  = int'(in_phase);
      if (m_ov != 0 && out_ready) begin
        log_d.push_back(m_od);
        log_w.push_back(m_ow);
        m_ov = 0;
      end
      if (restart) begin
        m_ov = 0; m_cnt = 0; m_err = 0; m_primed = 0;
      end else if (in_valid && rdy) begin
        if (ph >= M) m_err = 1;
        else if (m_primed == 0) begin
          m_prev = ph; m_primed = 1;
        end else begin
          m_od = (ph - m_prev + M) % M;
          m_ow = (ph < m_prev) ? 1 : 0;
          if (m_ow != 0) m_cnt = (m_cnt + 1) % (1 << CW);
          m_ov = 1;
          m_prev = ph;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("cyc in_ready", int'(in_ready), (!restart && (m_ov == 0 || out_ready)) ? 1 : 0);
      chk("cyc out_valid", int'(out_valid), m_ov);
      chk("cyc out_diff", int'(out_diff), m_od);
      chk("cyc out_wrap", int'(out_wrap), m_ow);
      chk("cyc wrap_cnt", int'(wrap_cnt), m_cnt);
      chk("cyc primed", int'(primed), m_primed);
      chk("cyc err", int'(err), m_err);
    end
  end

  task automatic send(input int p);
    bit acc = 0;
    in_valid = 1'b1;
    in_phase = W'(p);
    for (int k = 0; k < 200 && !acc; k++) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    idle(1);
    restart = 1'b0;
    log_d.delete();
    log_w.delete();
  endtask

  task automatic chk_log(input string nm);
    chk({nm, " count"}, log_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < log_d.size(); i++) begin
      chk({nm, " diff"}, log_d[i], exp_d[i]);
      chk({nm, " wrap"}, log_w[i], exp_w[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int x, bad, nw;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst primed", int'(primed), 0);
    chk("rst err", int'(err), 0);
    chk("rst wrap_cnt", int'(wrap_cnt), 0);
    chk("rst in_ready", int'(in_ready), 1);

    // 1: basic
    send(10);
    chk("t1 primed", int'(primed), 1);
    chk("t1 no out", int'(out_valid), 0);
    send(30);
    chk("t1 latency", int'(out_valid), 1);
    send(50); send(70); idle(2);
    exp_d = '{20, 20, 20}; exp_w = '{0, 0, 0};
    chk_log("t1");

    // 2: wrap
    do_restart();
    send(90); send(5); send(5); send(99); send(0); idle(2);
    exp_d = '{15, 0, 94, 1}; exp_w = '{1, 0, 0, 1};
    chk_log("t2");
    chk("t2 wrap_cnt", int'(wrap_cnt), 2);

    // 3: backpressure
    do_restart();
    send(0); send(7);
    out_ready = 1'b0;
    in_valid = 1'b1; in_phase = W'(14);
    repeat (3) begin
      @(negedge clk);
      chk("t3 stall in_ready", int'(in_ready), 0);
      chk("t3 stall diff", int'(out_diff), 7);
      chk("t3 stall valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(14); send(21); idle(2);
    exp_d = '{7, 7, 7}; exp_w = '{0, 0, 0};
    chk_log("t3");

    // 4: range error
    do_restart();
    send(10); send(100);
    chk("t4 err set", int'(err), 1);
    send(40); idle(3);
    exp_d = '{30}; exp_w = '{0};
    chk_log("t4");
    chk("t4 err sticky", int'(err), 1);
    do_restart();
    chk("t4 err cleared", int'(err), 0);

    // 5: restart with pending input, then async reset
    send(10); send(20);
    restart = 1'b1; in_valid = 1'b1; in_phase = W'(60);
    @(negedge clk);
    chk("t5 restart in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    restart = 1'b0; in_valid = 1'b0;
    chk("t5 out_valid", int'(out_valid), 0);
    chk("t5 wrap_cnt", int'(wrap_cnt), 0);
    chk("t5 primed", int'(primed), 0);
    log_d.delete(); log_w.delete();
    send(60); send(65); idle(2);
    exp_d = '{5}; exp_w = '{0};
    chk_log("t5");
    out_ready = 1'b0;
    send(70);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 arst out_valid", int'(out_valid), 0);
    chk("t5 arst out_diff", int'(out_diff), 0);
    chk("t5 arst out_wrap", int'(out_wrap), 0);
    chk("t5 arst wrap_cnt", int'(wrap_cnt), 0);
    chk("t5 arst primed", int'(primed), 0);
    chk("t5 arst err", int'(err), 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // 6: round trip from a modulo-100 accumulator, increment 37
    do_restart();
    rand_rdy = 1;
    x = 0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(x);
      x = (x + 37) % M;
    end
    rand_rdy = 0; out_ready = 1'b1; idle(3);
    bad = 0; nw = 0;
    foreach (log_d[i]) begin
      if (log_d[i] != 37) bad++;
      nw += log_w[i];
    end
    chk("t6 count", log_d.size(), 199);
    chk("t6 bad diffs", bad, 0);
    chk("t6 wrap flags", nw, 73);
    chk("t6 wrap_cnt", int'(wrap_cnt), 73);

    // random stream including out-of-range samples and restarts
    do_restart();
    rand_rdy = 1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      if ($urandom_range(0, 40) == 0) do_restart();
      send($urandom_range(0, M + 9));
    end
    rand_rdy = 0; out_ready = 1'b1; idle(3);

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
